// File: rtl/prefix_sum_stage.sv
// rtl/prefix_sum_stage.sv - two-register adder back end fed by an external group prefix tree
// Optional ADDER_OVERFLOW_EN adds a registered signed-overflow output.
`ifndef INPUTSIZE
`define INPUTSIZE 32
`endif
`ifndef GROUPSIZE
`define GROUPSIZE 4
`endif

module prefix_sum_stage #(
  parameter int INPUTSIZE = `INPUTSIZE,
  parameter int GROUPSIZE = `GROUPSIZE,
  localparam int TREESIZE = INPUTSIZE / GROUPSIZE
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [INPUTSIZE-1:0]  a,
  input  logic [INPUTSIZE-1:0]  b,
  input  logic                  cin,
  input  logic [2*TREESIZE-1:0] r,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [INPUTSIZE-1:0]  sum,
`ifdef ADDER_OVERFLOW_EN
  output logic                  overflow,
`endif
  output logic                  cout
);

  logic                  s1_valid;
  logic [INPUTSIZE-1:0]  s1_a;
  logic [INPUTSIZE-1:0]  s1_b;
  logic                  s1_cin;
  logic [2*TREESIZE-1:0] s1_r;

  logic                  s1_load;
  logic                  s2_load;

  logic [INPUTSIZE-1:0]  p;
  logic [INPUTSIZE-1:0]  g;
  logic [TREESIZE-1:0]   grp_cin;
  logic [INPUTSIZE-1:0]  carry;
  logic [INPUTSIZE-1:0]  sum_next;
  logic                  cout_next;

  assign s2_load  = s1_valid && (!out_valid || out_ready);
  assign s1_load  = !s1_valid || s2_load;
  assign in_ready = s1_load;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_cin   <= 1'b0;
      s1_r     <= '0;
    end else if (s1_load) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_a   <= a;
        s1_b   <= b;
        s1_cin <= cin;
        s1_r   <= r;
      end
    end
  end

  assign p = s1_a ^ s1_b;
  assign g = s1_a & s1_b;

  // Group carry-ins come straight from the registered prefix pairs, not from a/b.
  always_comb begin
    grp_cin    = '0;
    grp_cin[0] = s1_cin;
    for (int k = 1; k < TREESIZE; k++) begin
      grp_cin[k] = s1_r[2*k-1] | (s1_r[2*k-2] & s1_cin);
    end
  end

  always_comb begin
    logic c;
    c     = 1'b0;
    carry = '0;
    for (int k = 0; k < TREESIZE; k++) begin
      c = grp_cin[k];
      for (int j = 0; j < GROUPSIZE; j++) begin
        carry[k*GROUPSIZE+j] = c;
        c = g[k*GROUPSIZE+j] | (p[k*GROUPSIZE+j] & c);
      end
    end
  end

  assign sum_next  = p ^ carry;
  assign cout_next = s1_r[2*TREESIZE-1] | (s1_r[2*TREESIZE-2] & s1_cin);

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
    end else if (s2_load) begin
      out_valid <= 1'b1;
      sum       <= sum_next;
      cout      <= cout_next;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef ADDER_OVERFLOW_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (s2_load) begin
      overflow <= carry[INPUTSIZE-1] ^ cout_next;
    end
  end
`endif

endmodule

// File: tb/tb_prefix_sum_stage.sv
// tb/tb_prefix_sum_stage.sv - directed self-checking bench for prefix_sum_stage
module tb_prefix_sum_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        cin;
  logic [15:0] r;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] sum;
  logic        cout;
`ifdef ADDER_OVERFLOW_EN
  logic        overflow;
`endif

  int total = 0;
  int bad   = 0;

  logic [31:0] va [8];
  logic [31:0] vb [8];
  logic        vc [8];
  logic [32:0] ve [8];

  prefix_sum_stage #(.INPUTSIZE(32), .GROUPSIZE(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .r         (r),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
`ifdef ADDER_OVERFLOW_EN
    .overflow  (overflow),
`endif
    .cout      (cout)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] prefix_r(input logic [31:0] x, input logic [31:0] y);
    logic [15:0] res;
    logic gg, pp, gacc, pacc;
    res  = '0;
    gacc = 1'b0;
    pacc = 1'b1;
    for (int k = 0; k < 8; k++) begin
      gg = 1'b0;
      pp = 1'b1;
      for (int j = 0; j < 4; j++) begin
        gg = (x[4*k+j] & y[4*k+j]) | ((x[4*k+j] ^ y[4*k+j]) & gg);
        pp = pp & (x[4*k+j] ^ y[4*k+j]);
      end
      gacc = gg | (pp & gacc);
      pacc = pp & pacc;
      res[2*k+1] = gacc;
      res[2*k]   = pacc;
    end
    return res;
  endfunction

  task automatic drive(input logic [31:0] x, input logic [31:0] y, input logic ci);
    a   = x;
    b   = y;
    cin = ci;
    r   = prefix_r(x, y);
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    drive(32'h0, 32'h0, 1'b0);
    tick();
    tick();
    chk("reset_out_valid", out_valid, 0);
    chk("reset_sum", sum, 0);
    chk("reset_cout", cout, 0);
    chk("reset_in_ready", in_ready, 1);
    rst = 1'b0;

    // wrap to zero with carry-out, latency check
    drive(32'hFFFF_FFFF, 32'h1, 1'b0);
    in_valid = 1'b1;
    chk("wrap_in_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    chk("wrap_lat1_valid", out_valid, 0);
    tick();
    chk("wrap_lat2_valid", out_valid, 1);
    chk("wrap_sum", sum, 32'h0000_0000);
    chk("wrap_cout", cout, 1);
    tick();
    chk("wrap_drained", out_valid, 0);

    drive(32'h7FFF_FFFF, 32'h1, 1'b0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    chk("ovf_valid", out_valid, 1);
    chk("ovf_sum", sum, 32'h8000_0000);
    chk("ovf_cout", cout, 0);
`ifdef ADDER_OVERFLOW_EN
    chk("ovf_flag", overflow, 1);
`endif
    tick();

    drive(32'h0, 32'h0, 1'b1);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    chk("cin_valid", out_valid, 1);
    chk("cin_sum", sum, 32'h1);
    chk("cin_cout", cout, 0);
`ifdef ADDER_OVERFLOW_EN
    chk("cin_flag", overflow, 0);
`endif
    tick();

    // back-to-back throughput with out_ready held high
    for (int i = 0; i < 8; i++) begin
      va[i] = $urandom;
      vb[i] = $urandom;
      vc[i] = 1'($urandom_range(0, 1));
      ve[i] = {1'b0, va[i]} + {1'b0, vb[i]} + {32'b0, vc[i]};
    end
    va[3] = 32'h8000_0000; vb[3] = 32'h8000_0000; vc[3] = 1'b1;
    ve[3] = 33'h1_0000_0001;
    for (int i = 0; i < 10; i++) begin
      if (i < 8) begin
        drive(va[i], vb[i], vc[i]);
        in_valid = 1'b1;
        chk($sformatf("tp_in_ready_%0d", i), in_ready, 1);
      end else begin
        in_valid = 1'b0;
        #1;
      end
      tick();
      if (i >= 1 && i <= 8) begin
        chk($sformatf("tp_valid_%0d", i - 1), out_valid, 1);
        chk($sformatf("tp_sum_%0d", i - 1), sum, ve[i-1][31:0]);
        chk($sformatf("tp_cout_%0d", i - 1), cout, ve[i-1][32]);
      end else begin
        chk($sformatf("tp_idle_%0d", i), out_valid, 0);
      end
    end

    // stall: three offered, two accepted, then ordered drain
    out_ready = 1'b0;
    drive(32'h10, 32'h01, 1'b0);
    in_valid = 1'b1;
    chk("st_rdy1", in_ready, 1);
    tick();
    drive(32'h100, 32'h200, 1'b0);
    chk("st_rdy2", in_ready, 1);
    tick();
    drive(32'hFFFF_0000, 32'h0001_0000, 1'b0);
    chk("st_rdy3", in_ready, 0);
    chk("st_valid", out_valid, 1);
    chk("st_sum_a", sum, 32'h11);
    tick();
    chk("st_rdy3_hold", in_ready, 0);
    chk("st_sum_hold", sum, 32'h11);
    chk("st_cout_hold", cout, 0);
    out_ready = 1'b1;
    #1;
    chk("st_rdy_release", in_ready, 1);
    tick();
    in_valid = 1'b0;
    chk("st_out2_valid", out_valid, 1);
    chk("st_out2_sum", sum, 32'h300);
    tick();
    chk("st_out3_valid", out_valid, 1);
    chk("st_out3_sum", sum, 32'h0);
    chk("st_out3_cout", cout, 1);
    tick();
    chk("st_drained", out_valid, 0);

    // reset while both stages hold data
    out_ready = 1'b0;
    drive(32'h1234_5678, 32'h1111_1111, 1'b0);
    in_valid = 1'b1;
    tick();
    drive(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    tick();
    in_valid = 1'b0;
    chk("rf_full_valid", out_valid, 1);
    chk("rf_full_ready", in_ready, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rf_valid", out_valid, 0);
    chk("rf_sum", sum, 0);
    chk("rf_cout", cout, 0);
    chk("rf_in_ready", in_ready, 1);
`ifdef ADDER_OVERFLOW_EN
    chk("rf_flag", overflow, 0);
`endif
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("rf_no_stale_%0d", i), out_valid, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/prefix_sum_stage.md
PREFIX_SUM_STAGE -- requirements
Module: prefix_sum_stage

Interface
REQ-001 SHALL have parameter INPUTSIZE, default `INPUTSIZE (32), operand width in bits.
REQ-002 SHALL have parameter GROUPSIZE, default `GROUPSIZE (4), bits per carry group; INPUTSIZE divisible by GROUPSIZE; Treesize = INPUTSIZE/GROUPSIZE, power of two, >= 4.
REQ-003 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port in_valid, input, 1, upstream transaction present.
REQ-006 SHALL have port in_ready, output, 1, stage accepts transaction this cycle.
REQ-007 SHALL have port a, input, INPUTSIZE, operand A.
REQ-008 SHALL have port b, input, INPUTSIZE, operand B.
REQ-009 SHALL have port cin, input, 1, adder carry-in.
REQ-010 SHALL have port r, input, Treesize*2, group-prefix pairs from the prefix tree; pair k: r[2k+1] = G(0..k), r[2k] = P(0..k).
REQ-011 SHALL have port out_valid, output, 1, result present.
REQ-012 SHALL have port out_ready, input, 1, downstream accepts result.
REQ-013 SHALL have port sum, output, INPUTSIZE, registered a+b+cin modulo 2^INPUTSIZE.
REQ-014 SHALL have port cout, output, 1, registered carry-out.

Function
REQ-015 SHALL be a two-register pipeline: S1 captures a, b, cin, r; S2 captures sum, cout.
REQ-016 Transfer in SHALL occur when in_valid && in_ready; transfer out when out_valid && out_ready.
REQ-017 S2 SHALL load when S1 valid and (!out_valid || out_ready); S1 SHALL load when (!S1 valid || S2 loads).
REQ-018 in_ready SHALL equal !S1_valid || S2 load condition (combinational, no dependency on in_valid).
REQ-019 Latency SHALL be 2 cycles accept-to-out_valid; throughput one result per cycle when out_ready held high.
REQ-020 Group carry-in SHALL be c0 = cin, ck = r[2k-1] | (r[2k-2] & cin) for k >= 1, from registered S1 values.
REQ-021 Within a group, bit carries SHALL ripple from group carry-in using p = a^b, g = a&b; sum[i] = p[i] ^ c[i].
REQ-022 cout SHALL equal r[2*Treesize-1] | (r[2*Treesize-2] & cin).
REQ-023 Under stall (out_valid && !out_ready) sum, cout SHALL hold stable; S1 SHALL hold; no transaction lost or duplicated; order preserved.
REQ-024 Simultaneous accept and output in the same cycle with both stages full SHALL be lossless (full throughput).
REQ-025 r inconsistent with a, b SHALL not be detected; output follows REQ-020..022 regardless.

Reset
REQ-026 On rst high at a clock edge: S1_valid=0, out_valid=0, sum=0, cout=0, S1 data=0; in_ready=1 the cycle after.
REQ-027 rst SHALL override any simultaneous handshake; in-flight transactions discarded.

Configuration
REQ-028 Macro ADDER_OVERFLOW_EN defined: port overflow, output, 1, registered with sum, = carry into bit INPUTSIZE-1 XOR cout; reset 0; held under stall.
REQ-029 Macro ADDER_OVERFLOW_EN undefined: overflow port and logic absent; all other behaviour identical.

Verification (INPUTSIZE=32, GROUPSIZE=4, r from golden prefix model)
REQ-030 a=0xFFFFFFFF, b=1, cin=0 accepted cycle t -> out_valid at t+2, sum=0x00000000, cout=1.
REQ-031 a=0x7FFFFFFF, b=1, cin=0 -> sum=0x80000000, cout=0, overflow=1 (macro on); a=b=0, cin=1 -> sum=1, cout=0, overflow=0.
REQ-032 8 back-to-back random vectors, out_ready=1 -> in_ready constant 1, 8 results in consecutive cycles, in order, matching a+b+cin.
REQ-033 out_ready=0, 3 vectors offered -> 2 accepted, in_ready=0 after second, sum stable; out_ready=1 -> results 1,2,3 delivered in order.
REQ-034 rst pulse with both stages valid -> next cycle out_valid=0, sum=0, cout=0, in_ready=1; no stale result emitted afterward.
